// File: rtl/apb_slave_regs.sv
// APB completer: NUM_REGS x 32-bit R/W registers at BASE_ADDR, fixed wait states, flat regs_o view.
// Optional APB_SLAVE_PSLVERR_EN adds a registered pslverr response for decode misses.
module apb_slave_regs #(
   parameter logic [31:0] BASE_ADDR   = 32'hA000,
   parameter int          NUM_REGS    = 4,
   parameter int          WAIT_STATES = 1
) (
   input  logic                   pclk,
   input  logic                   preset_n,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [31:0]            paddr,
   input  logic [31:0]            pwdata,
   output logic [31:0]            prdata,
   output logic                   pready,
`ifdef APB_SLAVE_PSLVERR_EN
   output logic                   pslverr,
`endif
   output logic [NUM_REGS*32-1:0] regs_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
   // The counter holds the WAIT cycles left after the current one, so pready lands in T+1+WAIT_STATES.
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t      r_state;
   logic [3:0]  r_wait_cnt;
   logic        r_hit;
   logic        r_wr;
   logic [3:0]  r_idx;
   logic [31:0] r_wdata;
   logic [31:0] r_rd_cap;
   logic [31:0] r_prdata;
   logic        r_pready;
   logic [31:0] r_regs [NUM_REGS];

   logic [31:0] w_offset;
   logic        w_hit;
   logic [3:0]  w_idx;
   logic [31:0] w_rdata;
   logic        w_resp_next;
   logic        w_resp_wr;
   logic [31:0] w_resp_rd;

   always_comb begin
      w_offset = paddr - BASE_ADDR;
      w_hit    = (paddr >= BASE_ADDR) && (w_offset < SPAN) && (paddr[1:0] == 2'b00);
      w_idx    = w_offset[5:2];
   end

   always_comb begin
      w_rdata = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_rdata = w_rdata | ((w_hit && (w_idx == 4'(i))) ? r_regs[i] : 32'h0);
      end
   end

   // Decides whether the next cycle is the pready cycle, and with which captured transfer.
   always_comb begin
      w_resp_next = 1'b0;
      w_resp_wr   = r_wr;
      w_resp_rd   = r_rd_cap;
      case (r_state)
         ST_IDLE: begin
            w_resp_next = psel && penable && (WAIT_STATES == 0);
            w_resp_wr   = pwrite;
            w_resp_rd   = w_rdata;
         end
         ST_WAIT: begin
            w_resp_next = psel && (r_wait_cnt == 4'd0);
         end
         ST_RESP: begin
            w_resp_next = 1'b0;
         end
         default: begin
            w_resp_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
         r_hit      <= 1'b0;
         r_wr       <= 1'b0;
         r_idx      <= 4'd0;
         r_wdata    <= 32'h0;
         r_rd_cap   <= 32'h0;
         r_prdata   <= 32'h0;
         r_pready   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= 32'h0;
         end
      end else begin
         r_pready <= w_resp_next;
         if (w_resp_next && !w_resp_wr) begin
            r_prdata <= w_resp_rd;
         end
         case (r_state)
            ST_IDLE: begin
               if (psel && penable) begin
                  r_hit    <= w_hit;
                  r_wr     <= pwrite;
                  r_idx    <= w_idx;
                  r_wdata  <= pwdata;
                  r_rd_cap <= w_rdata;
                  if (WAIT_STATES == 0) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state    <= ST_WAIT;
                     r_wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (!psel) begin
                  r_state    <= ST_IDLE;
                  r_wait_cnt <= 4'd0;
               end else if (r_wait_cnt == 4'd0) begin
                  r_state <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (r_wr && r_hit && (r_idx == 4'(i))) begin
                     r_regs[i] <= r_wdata;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef APB_SLAVE_PSLVERR_EN
   logic r_pslverr;
   logic w_resp_miss;

   assign w_resp_miss = (r_state == ST_IDLE) ? !w_hit : !r_hit;

   // Error flag rides alongside pready and is set only for a decode miss.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         r_pslverr <= 1'b0;
      end else begin
         r_pslverr <= w_resp_next && w_resp_miss;
      end
   end

   assign pslverr = r_pslverr;
`endif

   assign prdata = r_prdata;
   assign pready = r_pready;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
      assign regs_o[g*32 +: 32] = r_regs[g];
   end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: three instances (WAIT_STATES 1, 0, 3), directed and random APB
// transfers checked against an address-map model; honours APB_SLAVE_PSLVERR_EN.
module tb_apb_slave_regs;
   localparam int          NR   = 4;
   localparam int          NI   = 3;
   localparam logic [31:0] BASE = 32'hA000;

   logic              pclk = 1'b0;
   logic              preset_n = 1'b0;
   logic [NI-1:0]     psel = '0;
   logic              penable = 1'b0;
   logic              pwrite = 1'b0;
   logic [31:0]       paddr = 32'h0;
   logic [31:0]       pwdata = 32'h0;
   logic [31:0]       prdata_v [NI];
   logic              pready_v [NI];
   logic              pslverr_v [NI];
   logic [NR*32-1:0]  regs_v [NI];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_regs [NI][NR];
   logic [31:0] m_prdata [NI];

   always #5 pclk = ~pclk;

   apb_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(1)) u_dut_ws1 (
      .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
`ifdef APB_SLAVE_PSLVERR_EN
      .pslverr(pslverr_v[0]),
`endif
      .regs_o(regs_v[0]));

   apb_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(0)) u_dut_ws0 (
      .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
`ifdef APB_SLAVE_PSLVERR_EN
      .pslverr(pslverr_v[1]),
`endif
      .regs_o(regs_v[1]));

   apb_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(3)) u_dut_ws3 (
      .pclk(pclk), .preset_n(preset_n), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
`ifdef APB_SLAVE_PSLVERR_EN
      .pslverr(pslverr_v[2]),
`endif
      .regs_o(regs_v[2]));

`ifndef APB_SLAVE_PSLVERR_EN
   assign pslverr_v[0] = 1'b0;
   assign pslverr_v[1] = 1'b0;
   assign pslverr_v[2] = 1'b0;
`endif

   function automatic int ws_of(input int inst);
      case (inst)
         0: return 1;
         1: return 0;
         default: return 3;
      endcase
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      longint unsigned a64;
      a64 = longint'(a);
      return (a64 >= longint'(BASE)) && (a64 < longint'(BASE) + 4 * NR) && (a64 % 4 == 0);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [NR*32-1:0] m_vec(input int inst);
      logic [NR*32-1:0] v;
      for (int r = 0; r < NR; r++) v[r*32 +: 32] = m_regs[inst][r];
      return v;
   endfunction

   function automatic logic [31:0] m_read(input int inst, input logic [31:0] a);
      return m_hit(a) ? m_regs[inst][m_idx(a)] : 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_prdata[i] = 32'h0;
         for (int r = 0; r < NR; r++) m_regs[i][r] = 32'h0;
      end
   endtask

   // Model update after a completed transfer; returns the prdata expected in its pready cycle.
   task automatic model_apply(input int inst, input bit wr, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd);
      if (wr) begin
         if (m_hit(a)) m_regs[inst][m_idx(a)] = d;
      end else begin
         m_prdata[inst] = m_read(inst, a);
      end
      exp_rd = m_prdata[inst];
   endtask

   task automatic apb_xfer(input int inst, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic [31:0] rd, output logic err,
                           output logic ready_after, output logic [NR*32-1:0] regs_after);
      @(posedge pclk); #1;
      psel = '0; psel[inst] = 1'b1; penable = 1'b0; pwrite = wr; paddr = 32'h0; pwdata = data;
      @(posedge pclk); #1;
      penable = 1'b1; paddr = addr;
      lat = 0; rd = 32'h0; err = 1'b0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge pclk);
         if (pready_v[inst] === 1'b1) begin
            lat = c; rd = prdata_v[inst]; err = pslverr_v[inst];
         end
      end
      @(posedge pclk); #1;
      psel = '0; penable = 1'b0; paddr = 32'h0;
      @(negedge pclk);
      ready_after = pready_v[inst];
      regs_after  = regs_v[inst];
   endtask

   task automatic test_reset();
      preset_n = 1'b0; psel = '0; penable = 1'b0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      for (int i = 0; i < NI; i++) begin
         n_cmp++; if (pready_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_pready[%0d]: got %b want 0", i, pready_v[i]); end
         n_cmp++; if (prdata_v[i] !== 32'h0) begin n_err++; $display("FAIL reset_prdata[%0d]: got %h want 0", i, prdata_v[i]); end
         n_cmp++; if (regs_v[i] !== '0) begin n_err++; $display("FAIL reset_regs[%0d]: got %h want 0", i, regs_v[i]); end
`ifdef APB_SLAVE_PSLVERR_EN
         n_cmp++; if (pslverr_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_pslverr[%0d]: got %b want 0", i, pslverr_v[i]); end
`endif
      end
      model_reset();
      @(posedge pclk); #1;
      preset_n = 1'b1;
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd, exp_rd; logic err, rdy_after; logic [NR*32-1:0] rv;
      apb_xfer(0, 1'b1, 32'hA004, 32'hDEADBEEF, lat, rd, err, rdy_after, rv);
      model_apply(0, 1'b1, 32'hA004, 32'hDEADBEEF, exp_rd);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d want 3", lat); end
      n_cmp++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL wr_pready_width: got %b want 0", rdy_after); end
      n_cmp++; if (rv[63:32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_regs_o: got %h want deadbeef", rv[63:32]); end
      n_cmp++; if (rv !== m_vec(0)) begin n_err++; $display("FAIL wr_regs_all: got %h want %h", rv, m_vec(0)); end
      apb_xfer(0, 1'b0, 32'hA004, 32'h0, lat, rd, err, rdy_after, rv);
      model_apply(0, 1'b0, 32'hA004, 32'h0, exp_rd);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency: got %0d want 3", lat); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
`ifdef APB_SLAVE_PSLVERR_EN
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rd_pslverr: got %b want 0", err); end
`endif
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] rd, exp_rd, d, a; logic err, rdy_after; logic [NR*32-1:0] rv;
      for (int inst = 1; inst < NI; inst++) begin
         d = $urandom();
         a = BASE + 32'(4 * $urandom_range(0, NR - 1));
         apb_xfer(inst, 1'b1, a, d, lat, rd, err, rdy_after, rv);
         model_apply(inst, 1'b1, a, d, exp_rd);
         n_cmp++; if (lat !== ws_of(inst) + 2) begin n_err++; $display("FAIL ws_wr_latency[%0d]: got %0d want %0d", inst, lat, ws_of(inst) + 2); end
         n_cmp++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL ws_pready_width[%0d]: got %b want 0", inst, rdy_after); end
         n_cmp++; if (rv !== m_vec(inst)) begin n_err++; $display("FAIL ws_regs[%0d]: got %h want %h", inst, rv, m_vec(inst)); end
         apb_xfer(inst, 1'b0, a, 32'h0, lat, rd, err, rdy_after, rv);
         model_apply(inst, 1'b0, a, 32'h0, exp_rd);
         n_cmp++; if (lat !== ws_of(inst) + 2) begin n_err++; $display("FAIL ws_rd_latency[%0d]: got %0d want %0d", inst, lat, ws_of(inst) + 2); end
         n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL ws_rd_data[%0d]: got %h want %h", inst, rd, exp_rd); end
      end
   endtask

   task automatic test_miss();
      int lat; logic [31:0] rd, exp_rd; logic err, rdy_after; logic [NR*32-1:0] rv;
      logic [31:0] addrs [4];
      bit          wrs [4];
      addrs = '{32'hA010, 32'hA002, 32'h9FFC, 32'hA00C};
      wrs   = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) begin
         apb_xfer(0, wrs[k], addrs[k], 32'h1234, lat, rd, err, rdy_after, rv);
         model_apply(0, wrs[k], addrs[k], 32'h1234, exp_rd);
         n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL miss_latency[%h]: got %0d want 3", addrs[k], lat); end
         n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL miss_prdata[%h]: got %h want %h", addrs[k], rd, exp_rd); end
         n_cmp++; if (rv !== m_vec(0)) begin n_err++; $display("FAIL miss_regs[%h]: got %h want %h", addrs[k], rv, m_vec(0)); end
`ifdef APB_SLAVE_PSLVERR_EN
         n_cmp++; if (err !== !m_hit(addrs[k])) begin n_err++; $display("FAIL miss_pslverr[%h]: got %b want %b", addrs[k], err, !m_hit(addrs[k])); end
`endif
      end
   endtask

   task automatic test_random();
      int lat, inst; bit wr; logic [31:0] rd, exp_rd, a, d; logic err, rdy_after; logic [NR*32-1:0] rv;
      for (int n = 0; n < 60; n++) begin
         inst = int'($urandom_range(0, NI - 1));
         wr   = 1'($urandom_range(0, 1));
         d    = $urandom();
         case ($urandom_range(0, 4))
            0, 1: a = BASE + 32'(4 * $urandom_range(0, NR - 1));
            2:    a = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(1, 3));
            3:    a = BASE + 32'(4 * NR) + 32'(4 * $urandom_range(0, 3));
            default: a = ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : $urandom();
         endcase
         apb_xfer(inst, wr, a, d, lat, rd, err, rdy_after, rv);
         model_apply(inst, wr, a, d, exp_rd);
         n_cmp++; if (lat !== ws_of(inst) + 2) begin n_err++; $display("FAIL rnd_latency[%0d]: inst %0d got %0d want %0d", n, inst, lat, ws_of(inst) + 2); end
         n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_prdata[%0d]: inst %0d addr %h got %h want %h", n, inst, a, rd, exp_rd); end
         n_cmp++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL rnd_pready_width[%0d]: got %b want 0", n, rdy_after); end
         n_cmp++; if (rv !== m_vec(inst)) begin n_err++; $display("FAIL rnd_regs[%0d]: inst %0d got %h want %h", n, inst, rv, m_vec(inst)); end
`ifdef APB_SLAVE_PSLVERR_EN
         n_cmp++; if (err !== !m_hit(a)) begin n_err++; $display("FAIL rnd_pslverr[%0d]: addr %h got %b want %b", n, a, err, !m_hit(a)); end
`endif
      end
   endtask

   task automatic test_abort();
      int lat; bit seen; logic [31:0] rd, exp_rd; logic err, rdy_after; logic [NR*32-1:0] rv;
      for (int inst = 0; inst < NI; inst += 2) begin
         @(posedge pclk); #1;
         psel = '0; psel[inst] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h5A5A5A5A;
         @(posedge pclk); #1;
         penable = 1'b1; paddr = 32'hA000;
         @(posedge pclk); #1;
         psel = '0; penable = 1'b0; paddr = 32'h0;
         seen = 1'b0;
         repeat (6) begin
            @(negedge pclk);
            if (pready_v[inst] !== 1'b0) seen = 1'b1;
         end
         n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_pready[%0d]: got %b want 0", inst, seen); end
         n_cmp++; if (regs_v[inst] !== m_vec(inst)) begin n_err++; $display("FAIL abort_regs[%0d]: got %h want %h", inst, regs_v[inst], m_vec(inst)); end
         apb_xfer(inst, 1'b0, 32'hA000, 32'h0, lat, rd, err, rdy_after, rv);
         model_apply(inst, 1'b0, 32'hA000, 32'h0, exp_rd);
         n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL abort_readback[%0d]: got %h want %h", inst, rd, exp_rd); end
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit seen; logic [31:0] rd, exp_rd; logic err, rdy_after; logic [NR*32-1:0] rv;
      @(posedge pclk); #1;
      psel = '0; psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1111_2222;
      @(posedge pclk); #1;
      penable = 1'b1; paddr = 32'hA008;
      @(posedge pclk); #1;
      preset_n = 1'b0;
      @(posedge pclk); #1;
      preset_n = 1'b1; psel = '0; penable = 1'b0; paddr = 32'h0;
      model_reset();
      seen = 1'b0;
      repeat (4) begin
         @(negedge pclk);
         if (pready_v[0] !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_pready: got %b want 0", seen); end
      for (int i = 0; i < NI; i++) begin
         n_cmp++; if (regs_v[i] !== '0) begin n_err++; $display("FAIL rstmid_regs[%0d]: got %h want 0", i, regs_v[i]); end
         n_cmp++; if (prdata_v[i] !== 32'h0) begin n_err++; $display("FAIL rstmid_prdata[%0d]: got %h want 0", i, prdata_v[i]); end
      end
      apb_xfer(0, 1'b0, 32'hA008, 32'h0, lat, rd, err, rdy_after, rv);
      model_apply(0, 1'b0, 32'hA008, 32'h0, exp_rd);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rstmid_latency: got %0d want 3", lat); end
      n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rstmid_readback: got %h want %h", rd, exp_rd); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wait_states();
      test_miss();
      test_random();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within 500000 time units");
      $fatal(1, "timeout");
   end

endmodule
